// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - fetch unit state encoding and default width constants
package fetch_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_OPC_W  = 5;
  localparam int DEF_ADDR_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_fsm.sv
// rtl/fetch_fsm.sv - fetch sequencer IDLE/WAIT/DONE; FETCH_TIMEOUT_EN adds the ack watchdog and fetch_err
module fetch_fsm
  import fetch_pkg::*;
`ifdef FETCH_TIMEOUT_EN
#(
  parameter int TIMEOUT_CYC = 15
)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic sclr,
  input  logic fetch_start,
  input  logic pc_ld,
  input  logic mem_ack,
  output logic start_fetch,
  output logic ack_take,
  output logic idle,
  output logic mem_req,
  output logic fetch_busy,
  output logic fetch_done
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic fetch_err
`endif
);

  fetch_state_e state_q, state_d;
  logic         timeout;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter idles at zero, so it is already cleared on every entry to WAIT.
  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (state_q == ST_WAIT) begin
      cnt_d   = cnt_q + 1'b1;
      timeout = !mem_ack && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));
    end
    err_d = timeout;
  end

  always_ff @(posedge clk) begin
    if (!rst || sclr) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetch_err = err_q;
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst || sclr) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (fetch_start && !pc_ld) state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_ack) begin
          state_d = ST_DONE;
        end else if (timeout) begin
          state_d = ST_IDLE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    idle        = (state_q == ST_IDLE);
    mem_req     = (state_q == ST_WAIT);
    fetch_busy  = (state_q != ST_IDLE);
    fetch_done  = (state_q == ST_DONE);
    start_fetch = idle && fetch_start && !pc_ld;
    ack_take    = mem_req && mem_ack;
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - MAR/IR/PC datapath with autonomous fetch; FETCH_TIMEOUT_EN enables the ack watchdog
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                DATA_W   = DEF_DATA_W,
  parameter int                OPC_W    = DEF_OPC_W,
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] PC_RESET = '0
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int                TIMEOUT_CYC = 15
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    sclr,
  input  logic [DATA_W-1:0]       BUS_c,
  input  logic                    ir_en,
  input  logic                    mar_en,
  input  logic                    pc_ld,
  input  logic                    fetch_start,
  input  logic [DATA_W-1:0]       mem_rdata,
  input  logic                    mem_ack,
  output logic                    mem_req,
  output logic [ADDR_W-1:0]       q_addressBus,
  output logic [OPC_W-1:0]        q_controlUnit,
  output logic [DATA_W-OPC_W-1:0] q_operand,
  output logic [ADDR_W-1:0]       q_pc,
  output logic                    fetch_busy,
  output logic                    fetch_done
`ifdef FETCH_TIMEOUT_EN
  ,
  output logic                    fetch_err
`endif
);

  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              start_fetch, ack_take, idle;

`ifdef FETCH_TIMEOUT_EN
  fetch_fsm #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_fsm (
`else
  fetch_fsm u_fsm (
`endif
    .clk         (clk),
    .rst         (rst),
    .sclr        (sclr),
    .fetch_start (fetch_start),
    .pc_ld       (pc_ld),
    .mem_ack     (mem_ack),
    .start_fetch (start_fetch),
    .ack_take    (ack_take),
    .idle        (idle),
    .mem_req     (mem_req),
    .fetch_busy  (fetch_busy),
    .fetch_done  (fetch_done)
`ifdef FETCH_TIMEOUT_EN
    ,
    .fetch_err   (fetch_err)
`endif
  );

  // Bus loads only land in IDLE; a won fetch_start overrides mar_en.
  always_comb begin
    mar_d = mar_q;
    ir_d  = ir_q;
    pc_d  = pc_q;
    if (idle) begin
      if (pc_ld) begin
        pc_d = BUS_c[ADDR_W-1:0];
      end
      if (start_fetch) begin
        mar_d = pc_q;
      end else if (mar_en) begin
        mar_d = BUS_c[ADDR_W-1:0];
      end
      if (ir_en) begin
        ir_d = BUS_c;
      end
    end
    if (ack_take) begin
      ir_d = mem_rdata;
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst || sclr) begin
      mar_q <= '0;
      ir_q  <= '0;
      pc_q  <= PC_RESET;
    end else begin
      mar_q <= mar_d;
      ir_q  <= ir_d;
      pc_q  <= pc_d;
    end
  end

  assign q_addressBus  = mar_q;
  assign q_pc          = pc_q;
  assign q_controlUnit = ir_q[DATA_W-1 -: OPC_W];
  assign q_operand     = ir_q[DATA_W-OPC_W-1:0];

endmodule
